arb_mux_rr: RTL and testbench



---
 rtl/arb_mux_rr_if.sv | 31 +++
 rtl/arb_mux_rr.sv | 87 ++++++++
 tb/tb_arb_mux_rr.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/arb_mux_rr_if.sv
`default_nettype none
// ============================================================================
// arb_mux_rr_if : valid/ready bundle between N producers, arb_mux_rr and sink
// Rev 1.0
// ============================================================================
interface arb_mux_rr_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
);
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic [SW-1:0]  out_sel;
  logic           out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );
endinterface
`default_nettype wire

// File: rtl/arb_mux_rr.sv
`default_nettype none
// ============================================================================
// arb_mux_rr : N-channel registered mux, manual select or round-robin arbiter
// Rev 1.0
// ============================================================================
module arb_mux_rr #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic        clk,
  input  logic        rst_n,
  arb_mux_rr_if.slave bus
);
  localparam logic [SW-1:0] c_LAST = SW'(N - 1);

  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_sel_q,  out_sel_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          w_load;
  logic          w_gnt_vld;
  logic [SW-1:0] w_gnt;

  // Map ptr+offset back into 0..N-1 without a divider (offset < N).
  function automatic logic [SW-1:0] f_wrap(input int v);
    return (v >= N) ? SW'(v - N) : SW'(v);
  endfunction

  assign w_load = !out_valid_q || bus.out_ready;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    if (!bus.mode) begin
      if (({1'b0, bus.sel} < (SW+1)'(N)) && bus.in_valid[bus.sel]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = bus.sel;
      end
    end else begin
      // Scan from the far end so the channel nearest ptr is the last to win.
      for (int i = N - 1; i >= 0; i--) begin
        if (bus.in_valid[f_wrap(int'(ptr_q) + i)]) begin
          w_gnt_vld = 1'b1;
          w_gnt     = f_wrap(int'(ptr_q) + i);
        end
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (w_load) begin
      out_valid_d = w_gnt_vld;
      if (w_gnt_vld) begin
        out_data_d = bus.in_data[w_gnt*W +: W];
        out_sel_d  = w_gnt;
        ptr_d      = (w_gnt == c_LAST) ? '0 : w_gnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  // in_ready is gated by rst_n so it reads 0 for the whole reset window.
  assign bus.in_ready  = (rst_n && w_load && w_gnt_vld) ? (N'(1) << w_gnt) : '0;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_arb_mux_rr.sv
`default_nettype none
// ============================================================================
// tb_arb_mux_rr : vector table, corner sequences and scoreboard for arb_mux_rr
// Rev 1.0
// ============================================================================
module tb_arb_mux_rr;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arb_mux_rr_if #(.N(4), .W(8)) bus4 ();
  arb_mux_rr_if #(.N(3), .W(8)) bus3 ();

  arb_mux_rr #(.N(4), .W(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  arb_mux_rr #(.N(3), .W(8)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] e_rdy;
    logic       e_ov;
    logic [1:0] e_sel;
    logic [7:0] e_data;
    logic [1:0] e_ptr;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  typedef struct {
    logic [7:0] data;
    logic [1:0] sel;
  } exp_t;
  exp_t sbq[$];

  // Independent reference grant for the 4-channel instance: {found, index}.
  function automatic logic [2:0] mgrant(input logic md, input logic [1:0] s,
                                        input logic [3:0] v, input logic [1:0] p);
    if (!md) return v[s] ? {1'b1, s} : 3'b000;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (int'(p) + k) % 4;
      if (v[idx]) return {1'b1, 2'(idx)};
    end
    return 3'b000;
  endfunction

  initial begin
    // mode sel valid ordy | in_ready ov sel data ptr  (ch0..3 = 11,22,33,44)
    tbl[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h33, 2'd3};
    tbl[1]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h33, 2'd3};
    tbl[2]  = '{1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 2'd2, 8'h33, 2'd3};
    tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44, 2'd0};
    tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11, 2'd1};
    tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22, 2'd2};
    tbl[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h33, 2'd3};
    tbl[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44, 2'd0};
    tbl[8]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22, 2'd2};
    tbl[9]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44, 2'd0};
    tbl[10] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22, 2'd2};
    tbl[11] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44, 2'd0};
    tbl[12] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, 8'h44, 2'd0};
    tbl[13] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, 8'h44, 2'd0};
    tbl[14] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, 8'h44, 2'd0};
    tbl[15] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11, 2'd1};
    tbl[16] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h11, 2'd1};
    tbl[17] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22, 2'd2};
    tbl[18] = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11, 2'd1};
    tbl[19] = '{1'b0, 2'd3, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h11, 2'd1};
    tbl[20] = '{1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44, 2'd0};
  end

  initial begin
    logic       m_ov;
    logic [1:0] m_ptr;
    logic [7:0] words [4];
    logic [2:0] g;
    logic [3:0] e_rdy;
    logic       r_mode, r_ordy;
    logic [1:0] r_sel;
    logic [3:0] r_valid;
    exp_t       e;

    bus4.in_data = 32'h44332211; bus4.in_valid = '0; bus4.mode = 1'b0;
    bus4.sel = '0; bus4.out_ready = 1'b1;
    bus3.in_data = 24'hA2A1A0; bus3.in_valid = '0; bus3.mode = 1'b1;
    bus3.sel = '0; bus3.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    chk("reset out_valid", 32'(bus4.out_valid), 32'd0);
    chk("reset ptr", 32'(dut4.ptr_q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table on the 4-channel instance.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus4.mode = tbl[i].mode; bus4.sel = tbl[i].sel;
      bus4.in_valid = tbl[i].valid; bus4.out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d in_ready", i), 32'(bus4.in_ready), 32'(tbl[i].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out_valid", i), 32'(bus4.out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("vec%0d out_sel", i), 32'(bus4.out_sel), 32'(tbl[i].e_sel));
      chk($sformatf("vec%0d out_data", i), 32'(bus4.out_data), 32'(tbl[i].e_data));
      chk($sformatf("vec%0d ptr", i), 32'(dut4.ptr_q), 32'(tbl[i].e_ptr));
    end

    // Asynchronous reset while a word is held.
    @(negedge clk);
    bus4.mode = 1'b1; bus4.in_valid = 4'b1111; bus4.out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(bus4.out_valid), 32'd0);
    chk("midrst out_data", 32'(bus4.out_data), 32'd0);
    chk("midrst out_sel", 32'(bus4.out_sel), 32'd0);
    chk("midrst ptr", 32'(dut4.ptr_q), 32'd0);
    chk("midrst in_ready", 32'(bus4.in_ready), 32'd0);
    bus4.in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Three-channel instance: wrap without reaching 3, then mode switch.
    bus3.mode = 1'b1; bus3.in_valid = 3'b111;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("n3 rr%0d out_sel", i), 32'(bus3.out_sel), 32'(i % 3));
      chk($sformatf("n3 rr%0d out_data", i), 32'(bus3.out_data), 32'(8'hA0 + 8'(i % 3)));
      chk($sformatf("n3 rr%0d ptr", i), 32'(dut3.ptr_q), 32'((i + 1) % 3));
    end
    @(negedge clk);
    bus3.mode = 1'b0; bus3.sel = 2'd2;
    @(posedge clk);
    #1;
    chk("n3 manual out_sel", 32'(bus3.out_sel), 32'd2);
    chk("n3 manual ptr", 32'(dut3.ptr_q), 32'd0);
    @(negedge clk);
    bus3.sel = 2'd3;
    #1;
    chk("n3 badsel in_ready", 32'(bus3.in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("n3 badsel out_valid", 32'(bus3.out_valid), 32'd0);
    chk("n3 badsel out_sel", 32'(bus3.out_sel), 32'd2);
    bus3.in_valid = '0;

    // Random traffic against the reference model, starting from reset.
    @(negedge clk);
    rst_n = 1'b0;
    bus4.in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ov = 1'b0; m_ptr = '0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      r_mode  = 1'($urandom_range(0, 1));
      r_sel   = 2'($urandom_range(0, 3));
      r_valid = 4'($urandom);
      r_ordy  = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) words[k] = 8'($urandom);
      bus4.mode = r_mode; bus4.sel = r_sel; bus4.in_valid = r_valid;
      bus4.out_ready = r_ordy;
      bus4.in_data = {words[3], words[2], words[1], words[0]};
      #1;
      g = mgrant(r_mode, r_sel, r_valid, m_ptr);
      e_rdy = ((!m_ov || r_ordy) && g[2]) ? (4'b0001 << g[1:0]) : 4'b0000;
      chk("rnd in_ready", 32'(bus4.in_ready), 32'(e_rdy));
      chk("rnd onehot", 32'($countones(bus4.in_ready) <= 1), 32'd1);
      if (bus4.out_valid && r_ordy) begin
        if (sbq.size() == 0) begin
          chk("rnd duplicate word", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("rnd out_data", 32'(bus4.out_data), 32'(e.data));
          chk("rnd out_sel", 32'(bus4.out_sel), 32'(e.sel));
        end
      end
      if (!m_ov || r_ordy) begin
        m_ov = g[2];
        if (g[2]) begin
          sbq.push_back('{words[g[1:0]], g[1:0]});
          m_ptr = g[1:0] + 2'd1;
        end
      end
      @(posedge clk);
      #1;
      chk("rnd out_valid", 32'(bus4.out_valid), 32'(m_ov));
    end
    chk("rnd pending words", 32'(sbq.size()), 32'(m_ov));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
